// File: rtl/uart_cmd_wrapper.sv
// Remote command link endpoint: assembles two 8N1 UART bytes (high first) into a
// 16-bit command with a ready/clear handshake, and serialises an 8-bit response.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 5208,
    parameter int BYTE_TMO = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);
    localparam int CW      = $clog2(BAUD_DIV);
    localparam int TMO_CYC = BYTE_TMO * BAUD_DIV;
    localparam int TW      = $clog2(TMO_CYC);
    localparam logic [CW-1:0] L_BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] L_HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] L_TMO_END  = TW'(TMO_CYC - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {AS_HIGH, AS_LOW} as_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    // ---------------- RX bit engine ----------------
    logic            r_rx_ff1, r_rx_sync, r_rx_prev;
    rx_state_t       r_rx_state, w_rx_next;
    logic [CW-1:0]   r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            w_rx_cnt_clr, w_rx_sample, w_byte_stb, w_frm_err;

    always_comb begin
        w_rx_next    = r_rx_state;
        w_rx_cnt_clr = 1'b0;
        w_rx_sample  = 1'b0;
        w_byte_stb   = 1'b0;
        w_frm_err    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_next    = RX_START;
                    w_rx_cnt_clr = 1'b1;
                end
            end
            RX_START: begin
                if (r_rx_cnt == L_HALF_END) begin
                    w_rx_cnt_clr = 1'b1;
                    w_rx_next    = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == L_BIT_END) begin
                    w_rx_cnt_clr = 1'b1;
                    w_rx_sample  = 1'b1;
                    if (r_rx_bit == 3'd7)
                        w_rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == L_BIT_END) begin
                    w_rx_next  = RX_IDLE;
                    w_byte_stb = r_rx_sync;
                    w_frm_err  = !r_rx_sync;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ff1   <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_ff1   <= RX;
            r_rx_sync  <= r_rx_ff1;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= w_rx_cnt_clr ? '0 : r_rx_cnt + CW'(1);
            if (w_rx_sample)
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_state != RX_DATA)
                r_rx_bit <= '0;
            else if (w_rx_sample)
                r_rx_bit <= r_rx_bit + 3'd1;
        end
    end

    // ---------------- command assembler ----------------
    as_state_t       r_as_state, w_as_next;
    logic [TW-1:0]   r_tmo_cnt;
    logic            w_tmo_clr;
    logic [15:0]     r_cmd;
    logic            r_cmd_rdy, r_hi_pend;

    always_comb begin
        w_as_next = r_as_state;
        w_tmo_clr = 1'b0;
        case (r_as_state)
            AS_HIGH: begin
                if (w_byte_stb) begin
                    w_as_next = AS_LOW;
                    w_tmo_clr = 1'b1;
                end
            end
            AS_LOW: begin
                if (w_frm_err || w_byte_stb || r_tmo_cnt == L_TMO_END)
                    w_as_next = AS_HIGH;
            end
            default: w_as_next = AS_HIGH;
        endcase
    end

    // The inter-byte timeout only runs while the line is idle, never mid-byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_as_state <= AS_HIGH;
            r_tmo_cnt  <= '0;
            r_cmd      <= '0;
            r_cmd_rdy  <= 1'b0;
            r_hi_pend  <= 1'b0;
        end else begin
            r_as_state <= w_as_next;
            if (w_tmo_clr)
                r_tmo_cnt <= '0;
            else if (r_as_state == AS_LOW && r_rx_state == RX_IDLE)
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            r_hi_pend <= 1'b0;
            if (r_as_state == AS_HIGH && w_byte_stb) begin
                if (r_cmd_rdy) begin
                    r_cmd_rdy <= 1'b0;
                    r_hi_pend <= 1'b1;
                end else begin
                    r_cmd[15:8] <= r_rx_shift;
                end
            end else if (r_as_state == AS_LOW && w_byte_stb) begin
                r_cmd[7:0] <= r_rx_shift;
                r_cmd_rdy  <= 1'b1;
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
            // Deferred high-byte write; the shift register is untouched until the next frame's data.
            if (r_hi_pend)
                r_cmd[15:8] <= r_rx_shift;
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

    // ---------------- TX serialiser ----------------
    tx_state_t       r_tx_state, w_tx_next;
    logic [CW-1:0]   r_tx_cnt;
    logic [3:0]      r_tx_bit;
    logic [9:0]      r_tx_shift;
    logic            r_tx_done;
    logic            w_tx_load, w_tx_shift, w_tx_end;

    always_comb begin
        w_tx_next  = r_tx_state;
        w_tx_load  = 1'b0;
        w_tx_shift = 1'b0;
        w_tx_end   = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (trmt) begin
                    w_tx_next = TX_XMIT;
                    w_tx_load = 1'b1;
                end
            end
            TX_XMIT: begin
                if (r_tx_cnt == L_BIT_END) begin
                    if (r_tx_bit == 4'd9) begin
                        w_tx_next = TX_IDLE;
                        w_tx_end  = 1'b1;
                    end else begin
                        w_tx_shift = 1'b1;
                    end
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_load) begin
                r_tx_shift <= {1'b1, resp, 1'b0};
                r_tx_cnt   <= '0;
                r_tx_bit   <= '0;
                r_tx_done  <= 1'b0;
            end else if (w_tx_shift) begin
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_cnt   <= '0;
                r_tx_bit   <= r_tx_bit + 4'd1;
            end else if (r_tx_state == TX_XMIT) begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
            if (w_tx_end)
                r_tx_done <= 1'b1;
        end
    end

    assign TX      = (r_tx_state == TX_XMIT) ? r_tx_shift[0] : 1'b1;
    assign tx_done = r_tx_done;

endmodule
